// File: rtl/ltssm_pkg.sv
// rtl/ltssm_pkg.sv - LTSSM substate/LPIF codes and timeout lookup helpers
package ltssm_pkg;

    typedef enum logic [3:0] {
        SS_DETECT_QUIET   = 4'd0,
        SS_DETECT_ACTIVE  = 4'd1,
        SS_POLL_ACTIVE    = 4'd2,
        SS_POLL_CFG       = 4'd3,
        SS_CFG_LW_START   = 4'd4,
        SS_CFG_LW_ACCEPT  = 4'd5,
        SS_CFG_LN_WAIT    = 4'd6,
        SS_CFG_LN_ACCEPT  = 4'd7,
        SS_CFG_COMPLETE   = 4'd8,
        SS_CFG_IDLE       = 4'd9,
        SS_L0             = 4'd10
    } substate_e;

    typedef enum logic [3:0] {
        LPIF_RESET   = 4'd0,
        LPIF_ACTIVE  = 4'd1,
        LPIF_RETRAIN = 4'd11
    } lpif_e;

    localparam logic [3:0] TIMER_IDLE  = 4'hF;
    localparam logic [3:0] LAST_TIMED  = 4'd9;
    localparam logic [5:0] ELAPSED_MAX = 6'h3F;

    // Residency limit in ms for a timed substate (0..9).
    function automatic logic [5:0] limit_ms(
        input logic [3:0] st,
        input int         t_detect,
        input int         t_poll_act,
        input int         t_poll_cfg,
        input int         t_cfg_start,
        input int         t_cfg_short
    );
        case (st)
            SS_DETECT_QUIET, SS_DETECT_ACTIVE: return 6'(t_detect);
            SS_POLL_ACTIVE:                    return 6'(t_poll_act);
            SS_POLL_CFG:                       return 6'(t_poll_cfg);
            SS_CFG_LW_START:                   return 6'(t_cfg_start);
            default:                           return 6'(t_cfg_short);
        endcase
    endfunction

    function automatic logic [3:0] timeout_target(input logic [3:0] st);
        return (st == SS_DETECT_QUIET) ? SS_DETECT_ACTIVE : SS_DETECT_QUIET;
    endfunction

endpackage

// File: rtl/ltssm_timeout_ctrl_if.sv
// rtl/ltssm_timeout_ctrl_if.sv - LTSSM status in / timeout request out bundle
interface ltssm_timeout_ctrl_if;
    logic       timerEnable;
    logic [3:0] substateTx;
    logic [3:0] substateRx;
    logic [3:0] lpifStateStatus;
    logic       linkUp;
    logic       timeoutPulse;
    logic [3:0] timeoutGoto;
    logic       forceDetect;
    logic [3:0] timerState;
    logic [5:0] elapsedMs;

    modport master (
        output timerEnable, substateTx, substateRx, lpifStateStatus, linkUp,
        input  timeoutPulse, timeoutGoto, forceDetect, timerState, elapsedMs
    );

    modport slave (
        input  timerEnable, substateTx, substateRx, lpifStateStatus, linkUp,
        output timeoutPulse, timeoutGoto, forceDetect, timerState, elapsedMs
    );
endinterface

// File: rtl/ltssm_ms_prescaler.sv
// rtl/ltssm_ms_prescaler.sv - clk-cycle to 1 ms tick divider with clear and enable
module ltssm_ms_prescaler #(
    parameter int TICKS_PER_MS = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic msTick
);
    localparam int                CNT_W    = $clog2(TICKS_PER_MS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_MS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);
    assign msTick  = en && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ltssm_timeout_ctrl.sv
// rtl/ltssm_timeout_ctrl.sv - per-substate residency timer issuing LTSSM exit requests
module ltssm_timeout_ctrl
    import ltssm_pkg::*;
#(
    parameter int TICKS_PER_MS   = 100000,
    parameter int T_DETECT_MS    = 12,
    parameter int T_POLL_ACT_MS  = 24,
    parameter int T_POLL_CFG_MS  = 48,
    parameter int T_CFG_START_MS = 24,
    parameter int T_CFG_SHORT_MS = 2
) (
    input logic                 clk,
    input logic                 reset,
    ltssm_timeout_ctrl_if.slave bus
);
    logic [3:0] timer_state_q, timer_state_d;
    logic [5:0] elapsed_q, elapsed_d;
    logic       fired_q, fired_d;
    logic       pulse_q, pulse_d;
    logic [3:0] goto_q, goto_d;
    logic       force_q, force_d;

    logic       same_sub;
    logic       link_idle;
    logic       idle_clear;
    logic       entry;
    logic       counting;
    logic       ps_clear;
    logic       ms_tick;
    logic [5:0] limit;
    logic [5:0] elapsed_inc;

    assign same_sub   = (bus.substateTx == bus.substateRx);
    assign link_idle  = (bus.lpifStateStatus != 4'(LPIF_RESET)) || bus.linkUp;
    // A Tx/Rx disagreement is a transient: it freezes the timer rather than clearing it.
    assign idle_clear = link_idle || (same_sub && (bus.substateTx > LAST_TIMED));
    assign entry      = !idle_clear && same_sub && (bus.substateTx != timer_state_q);
    assign counting   = !idle_clear && same_sub && !entry && bus.timerEnable;
    assign ps_clear   = idle_clear || entry;

    assign limit = limit_ms(timer_state_q, T_DETECT_MS, T_POLL_ACT_MS, T_POLL_CFG_MS,
                            T_CFG_START_MS, T_CFG_SHORT_MS);
    assign elapsed_inc = elapsed_q + 6'd1;

    ltssm_ms_prescaler #(
        .TICKS_PER_MS (TICKS_PER_MS)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (ps_clear),
        .en     (counting),
        .msTick (ms_tick)
    );

    always_comb begin
        timer_state_d = timer_state_q;
        elapsed_d     = elapsed_q;
        fired_d       = fired_q;
        pulse_d       = 1'b0;
        goto_d        = 4'd0;
        force_d       = 1'b0;
        if (ps_clear) begin
            timer_state_d = idle_clear ? TIMER_IDLE : bus.substateTx;
            elapsed_d     = '0;
            fired_d       = 1'b0;
        end else if (counting && ms_tick) begin
            if (elapsed_q != ELAPSED_MAX) begin
                elapsed_d = elapsed_inc;
            end
            // The fired flag keeps an ignored request from being reissued.
            if (!fired_q && (elapsed_q != ELAPSED_MAX) && (elapsed_inc == limit)) begin
                pulse_d = 1'b1;
                goto_d  = timeout_target(timer_state_q);
                force_d = (timer_state_q >= 4'(SS_POLL_ACTIVE));
                fired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_state_q <= TIMER_IDLE;
            elapsed_q     <= '0;
            fired_q       <= 1'b0;
            pulse_q       <= 1'b0;
            goto_q        <= 4'd0;
            force_q       <= 1'b0;
        end else begin
            timer_state_q <= timer_state_d;
            elapsed_q     <= elapsed_d;
            fired_q       <= fired_d;
            pulse_q       <= pulse_d;
            goto_q        <= goto_d;
            force_q       <= force_d;
        end
    end

    assign bus.timeoutPulse = pulse_q;
    assign bus.timeoutGoto  = goto_q;
    assign bus.forceDetect  = force_q;
    assign bus.timerState   = timer_state_q;
    assign bus.elapsedMs    = elapsed_q;
endmodule

// File: tb/tb_ltssm_timeout_ctrl.sv
// tb/tb_ltssm_timeout_ctrl.sv - scoreboard bench for ltssm_timeout_ctrl with a cycle-count reference model
module tb_ltssm_timeout_ctrl;
    localparam int T = 4;

    typedef struct packed {
        logic [3:0] st;
        logic [5:0] el;
        logic       p;
        logic [3:0] g;
        logic       fd;
    } stat_t;

    typedef struct packed {
        logic [3:0] g;
        logic       fd;
    } pulse_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ltssm_timeout_ctrl_if bus();

    ltssm_timeout_ctrl #(.TICKS_PER_MS(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    stat_t  q_stat[$];
    pulse_t q_pulse[$];
    int checks = 0;
    int errors = 0;
    int edge_no = 0;
    int last_drv_edge = 0;
    int pulse_cnt = 0;
    int last_pulse_edge = -1;

    // Reference model: time in a substate is just a count of enabled cycles since entry.
    int m_state = 15;
    int m_n = 0;
    bit m_fired = 1'b0;
    int lim [10] = '{12, 12, 24, 48, 24, 2, 2, 2, 2, 2};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at edge %0d", name, act, exp, edge_no);
        end
    endtask

    task automatic model_step(input int tx, input int rx, input int lpif, input int lu,
                              input int en, input int rst);
        stat_t  s;
        pulse_t pe;
        bit     p = 1'b0;
        if (rst == 0) begin
            m_state = 15; m_n = 0; m_fired = 1'b0;
        end else if (lpif != 0 || lu != 0 || (tx == rx && tx > 9)) begin
            m_state = 15; m_n = 0; m_fired = 1'b0;
        end else if (tx != rx) begin
            // frozen
        end else if (tx != m_state) begin
            m_state = tx; m_n = 0; m_fired = 1'b0;
        end else if (en != 0) begin
            m_n++;
            if (!m_fired && m_n == T * lim[tx]) begin
                p = 1'b1;
                m_fired = 1'b1;
            end
        end
        s.st = 4'(m_state);
        s.el = 6'((m_n / T > 63) ? 63 : m_n / T);
        s.p  = p;
        s.g  = p ? ((m_state == 0) ? 4'd1 : 4'd0) : 4'd0;
        s.fd = p && (m_state >= 2);
        q_stat.push_back(s);
        if (p) begin
            pe.g  = s.g;
            pe.fd = s.fd;
            q_pulse.push_back(pe);
        end
    endtask

    task automatic drive(input int tx, input int rx, input int lpif, input int lu,
                         input int en, input int rst);
        @(negedge clk);
        reset               = rst[0];
        bus.substateTx      = 4'(tx);
        bus.substateRx      = 4'(rx);
        bus.lpifStateStatus = 4'(lpif);
        bus.linkUp          = lu[0];
        bus.timerEnable     = en[0];
        last_drv_edge       = edge_no + 1;
        model_step(tx, rx, lpif, lu, en, rst);
    endtask

    task automatic run(input int n, input int tx, input int rx, input int lpif,
                       input int lu, input int en);
        for (int i = 0; i < n; i++) drive(tx, rx, lpif, lu, en, 1);
    endtask

    always @(posedge clk) begin : monitor
        stat_t  e;
        stat_t  a;
        pulse_t pe;
        edge_no++;
        #1;
        if (q_stat.size() != 0) begin
            e = q_stat.pop_front();
            a = {bus.timerState, bus.elapsedMs, bus.timeoutPulse, bus.timeoutGoto, bus.forceDetect};
            check("status{state,ms,pulse,goto,force}", int'(a), int'(e));
        end
        if (bus.timeoutPulse) begin
            pulse_cnt++;
            last_pulse_edge = edge_no;
            if (q_pulse.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                pe = q_pulse.pop_front();
                check("pulse_goto", int'(bus.timeoutGoto), int'(pe.g));
                check("pulse_force", int'(bus.forceDetect), int'(pe.fd));
            end
        end
    end

    initial begin
        int ent;
        int pc0;
        reset               = 1'b1;
        bus.substateTx      = 4'd0;
        bus.substateRx      = 4'd0;
        bus.lpifStateStatus = 4'd0;
        bus.linkUp          = 1'b0;
        bus.timerEnable     = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("reset_state", int'(bus.timerState), 15);
        check("reset_ms", int'(bus.elapsedMs), 0);
        check("reset_pulse", int'({bus.timeoutPulse, bus.timeoutGoto, bus.forceDetect}), 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);

        // Detect.Quiet held
        pc0 = pulse_cnt;
        run(1, 0, 0, 0, 0, 1); ent = last_drv_edge;
        run(199, 0, 0, 0, 0, 1);
        check("dq_pulse_count", pulse_cnt - pc0, 1);
        check("dq_pulse_delay", last_pulse_edge - ent, 48);

        // Polling.Configuration held, then saturation
        pc0 = pulse_cnt;
        run(1, 3, 3, 0, 0, 1); ent = last_drv_edge;
        run(299, 3, 3, 0, 0, 1);
        check("pcfg_pulse_count", pulse_cnt - pc0, 1);
        check("pcfg_pulse_delay", last_pulse_edge - ent, 192);
        check("pcfg_saturate", int'(bus.elapsedMs), 63);

        // State change before expiry
        pc0 = pulse_cnt;
        run(7, 5, 5, 0, 0, 1);
        run(1, 6, 6, 0, 0, 1); ent = last_drv_edge;
        run(19, 6, 6, 0, 0, 1);
        check("chg_pulse_count", pulse_cnt - pc0, 1);
        check("chg_pulse_delay", last_pulse_edge - ent, 8);
        check("chg_state", int'(bus.timerState), 6);

        // State change on the exact expiry edge wins
        pc0 = pulse_cnt;
        run(8, 5, 5, 0, 0, 1);
        run(1, 7, 7, 0, 0, 1); ent = last_drv_edge;
        run(15, 7, 7, 0, 0, 1);
        check("race_pulse_count", pulse_cnt - pc0, 1);
        check("race_pulse_delay", last_pulse_edge - ent, 8);

        // Tx/Rx mismatch freezes
        pc0 = pulse_cnt;
        run(41, 4, 4, 0, 0, 1);
        run(30, 5, 4, 0, 0, 1);
        check("mismatch_frozen_ms", int'(bus.elapsedMs), 10);
        run(1, 5, 5, 0, 0, 1); ent = last_drv_edge;
        run(19, 5, 5, 0, 0, 1);
        check("mismatch_pulse_count", pulse_cnt - pc0, 1);
        check("mismatch_pulse_delay", last_pulse_edge - ent, 8);

        // L0 / LPIF active / link up keep the timer idle
        pc0 = pulse_cnt;
        run(250, 10, 10, 0, 0, 1);
        check("l0_state", int'(bus.timerState), 15);
        check("l0_ms", int'(bus.elapsedMs), 0);
        run(250, 2, 2, 1, 0, 1);
        run(100, 3, 3, 11, 0, 1);
        run(100, 3, 3, 0, 1, 1);
        check("idle_pulse_count", pulse_cnt - pc0, 0);

        // Reset while the pulse is in flight, then restart
        pc0 = pulse_cnt;
        run(1, 2, 2, 0, 0, 1); ent = last_drv_edge;
        run(96, 2, 2, 0, 0, 1);
        drive(2, 2, 0, 0, 1, 0);
        #1;
        check("async_rst_pulse", int'(bus.timeoutPulse), 0);
        check("async_rst_state", int'(bus.timerState), 15);
        check("async_rst_ms", int'(bus.elapsedMs), 0);
        check("pre_rst_pulse_delay", last_pulse_edge - ent, 96);
        drive(2, 2, 0, 0, 1, 0);
        run(1, 2, 2, 0, 0, 1); ent = last_drv_edge;
        run(119, 2, 2, 0, 0, 1);
        check("restart_pulse_count", pulse_cnt - pc0, 2);
        check("restart_pulse_delay", last_pulse_edge - ent, 96);

        // timerEnable low for 20 cycles delays expiry by 20
        run(20, 9, 9, 0, 0, 1);
        pc0 = pulse_cnt;
        run(1, 2, 2, 0, 0, 1); ent = last_drv_edge;
        run(49, 2, 2, 0, 0, 1);
        run(20, 2, 2, 0, 0, 0);
        run(80, 2, 2, 0, 0, 1);
        check("en_pulse_count", pulse_cnt - pc0, 1);
        check("en_pulse_delay", last_pulse_edge - ent, 116);

        // Enable dropped exactly on the expiry edge
        pc0 = pulse_cnt;
        run(1, 8, 8, 0, 0, 1); ent = last_drv_edge;
        run(7, 8, 8, 0, 0, 1);
        run(3, 8, 8, 0, 0, 0);
        run(10, 8, 8, 0, 0, 1);
        check("en_edge_pulse_count", pulse_cnt - pc0, 1);
        check("en_edge_pulse_delay", last_pulse_edge - ent, 11);

        // Randomised segments against the model
        for (int s = 0; s < 60; s++) begin
            int len, tx, rx, lpif, lu, en, rst;
            len  = $urandom_range(1, 40);
            tx   = $urandom_range(0, 12);
            rx   = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 10) : tx;
            lpif = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 1 : 11) : 0;
            lu   = ($urandom_range(0, 11) == 0) ? 1 : 0;
            en   = ($urandom_range(0, 5) == 0) ? 0 : 1;
            rst  = ($urandom_range(0, 19) == 0) ? 0 : 1;
            if (rst == 0) len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) drive(tx, rx, lpif, lu, en, rst);
        end

        @(posedge clk);
        #3;
        check("stat_queue_drained", q_stat.size(), 0);
        check("pulse_queue_drained", q_pulse.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
